// File: rtl/nn_pkg.sv
// Shared definitions for the CNN layer blocks.
// Holds map dimensions, element widths and the unpooling FSM state type.
package nn_pkg;

    localparam int IMG_DIM  = 28;
    localparam int POOL_DIM = 14;
    localparam int PIX_W    = 8;
    localparam int POOL_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } unpool_state_t;

endpackage

// File: rtl/unpool_addr_gen.sv
// Row-major walker over a DIM x DIM pooled map for 2x strided layers.
// Ports: clk, reset (async active-low), clear, advance -> idx, base, last.
module unpool_addr_gen #(
    parameter int DIM = 14,
    parameter int AW  = 10,
    parameter int IW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [IW-1:0] idx,
    output logic [AW-1:0] base,
    output logic          last
);

    localparam int SIDE = 2 * DIM;
    localparam int RW   = (DIM > 1) ? $clog2(DIM) : 1;

    logic [RW-1:0] row;
    logic [RW-1:0] col;

    assign last = (idx == IW'(DIM * DIM - 1));

    // Top-left corner of the 2x2 output block for (row, col).
    assign base = AW'(row) * AW'(2 * SIDE) + (AW'(col) << 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            idx <= '0;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (last) begin
                idx <= '0;
                row <= '0;
                col <= '0;
            end else begin
                idx <= idx + IW'(1);
                if (col == RW'(DIM - 1)) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + RW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/avg_unpooling_layer.sv
// 2x2 unpooling: expands a POOL_DIM^2 map into a (2*POOL_DIM)^2 map.
// Ports: clk, reset (async active-low), enable, pool[] -> img[], finished_unpool.
module avg_unpooling_layer #(
    parameter int POOL_DIM = nn_pkg::POOL_DIM,
    parameter int DATA_W   = nn_pkg::POOL_W,
    parameter int OUT_W    = 16,
    parameter int MODE     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] pool [0:POOL_DIM*POOL_DIM-1],
    output logic signed [OUT_W-1:0]  img  [0:4*POOL_DIM*POOL_DIM-1],
    output logic                     finished_unpool
);

    import nn_pkg::*;

    localparam int SIDE  = 2 * POOL_DIM;
    localparam int NPOOL = POOL_DIM * POOL_DIM;
    localparam int NIMG  = SIDE * SIDE;
    localparam int AW    = $clog2(NIMG);
    localparam int IW    = (NPOOL > 1) ? $clog2(NPOOL) : 1;

    unpool_state_t state_q;
    unpool_state_t state_d;

    logic          wr_last_q;
    logic          advance;
    logic          clear;
    logic          last;
    logic [IW-1:0] idx;
    logic [AW-1:0] base;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;

    logic signed [DATA_W-1:0] src;
    logic signed [DATA_W-1:0] shv;
    logic signed [OUT_W-1:0]  v;

    // The final element is committed on the edge that sets wr_last_q,
    // so RUN lingers one more cycle before DONE.
    assign advance = (state_q == RUN) && !wr_last_q;
    assign clear   = (state_q == IDLE);

    unpool_addr_gen #(
        .DIM (POOL_DIM),
        .AW  (AW),
        .IW  (IW)
    ) u_addr (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .idx     (idx),
        .base    (base),
        .last    (last)
    );

    assign a1 = base + AW'(1);
    assign a2 = base + AW'(SIDE);
    assign a3 = base + AW'(SIDE + 1);

    assign src = pool[idx];
    assign shv = (MODE == 0) ? (src >>> 2) : src;

    generate
        if (OUT_W < DATA_W) begin : g_sat
            localparam logic signed [DATA_W-1:0] HI =
                DATA_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
            localparam logic signed [DATA_W-1:0] LO = ~HI;
            always_comb begin
                v = shv[OUT_W-1:0];
                if (shv > HI) begin
                    v = HI[OUT_W-1:0];
                end else if (shv < LO) begin
                    v = LO[OUT_W-1:0];
                end
            end
        end else begin : g_ext
            assign v = OUT_W'(shv);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN:  if (wr_last_q) state_d = DONE;
            DONE: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign finished_unpool = (state_q == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_last_q <= 1'b0;
            for (int i = 0; i < NIMG; i++) begin
                img[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_last_q <= advance && last;
            if (advance) begin
                img[base] <= v;
                img[a1]   <= v;
                img[a2]   <= v;
                img[a3]   <= v;
            end
        end
    end

endmodule
